// File: rtl/uart_rx.sv
// uart_rx: 8-bit LSB-first async serial receiver with mid-bit sampling, valid/ready holding register and error pulses.
// Define UART_RX_PARITY_EN to add a parity bit (sense set by PARITY_ODD) between data and stop.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, nxt;
  logic [1:0] sync;
  logic rx_s, half_hit, full_hit, stop_done, good_par, deliver, load;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, sh_n;
  assign rx_s = sync[1];
  // the start-detect cycle already counts as busy, before the FSM leaves IDLE
  assign busy = (state != IDLE) | ~rx_s;
  assign half_hit = cnt == CW'(HALF - 1);
  assign full_hit = cnt == CW'(CLKS_PER_BIT - 1);
  assign deliver = stop_done & rx_s & good_par;
  assign load = deliver & (~rx_valid | rx_ready);
`ifdef UART_RX_PARITY_EN
  logic par_bit, par_n;
  assign good_par = (^shreg ^ par_bit) == PARITY_ODD;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      par_bit <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bit <= par_n;
      parity_err <= stop_done & rx_s & ~good_par;
    end
`else
  assign good_par = 1'b1 | PARITY_ODD;
  assign parity_err = 1'b0;
`endif
  always_comb begin
    nxt = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sh_n = shreg;
    stop_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n = par_bit;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        nxt = rx_s ? IDLE : START;
      end
      START: if (half_hit) begin
        cnt_n = '0;
        idx_n = '0;
        nxt = rx_s ? IDLE : DATA;
      end
      DATA: if (full_hit) begin
        cnt_n = '0;
        sh_n = {rx_s, shreg[7:1]};
        idx_n = idx + 1'b1;
        nxt = (idx == 3'd7) ? AFTER_DATA : DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (full_hit) begin
        cnt_n = '0;
        par_n = rx_s;
        nxt = STOP;
      end
`endif
      STOP: if (full_hit) begin
        cnt_n = '0;
        stop_done = 1'b1;
        nxt = rx_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        nxt = rx_s ? IDLE : WAIT_HIGH;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      state <= nxt;
      cnt <= cnt_n;
      idx <= idx_n;
      shreg <= sh_n;
      frame_err <= stop_done & ~rx_s;
      overrun <= deliver & ~load;
      rx_valid <= load | (rx_valid & ~rx_ready);
      if (load) rx_data <= shreg;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level scoreboard for uart_rx; each sent frame predicts its stop-sample cycle and outcome.
module tb_uart_rx;
  localparam int CPB = 8;
  localparam int HALF = CPB / 2;
  localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
  localparam bit PEN = 1'b1;
`else
  localparam int NB = 9;
  localparam bit PEN = 1'b0;
`endif
  localparam int DLY = HALF + NB * CPB + 1;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, busy, frame_err, overrun, parity_err;
  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .busy(busy), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err)
  );
  always #5 clk = ~clk;
  typedef struct {int s; logic [7:0] d; bit stop; bit par;} ev_t;
  ev_t q[$];
  int cyc = 0, vectors = 0, errs = 0;
  bit rnd = 1'b0;
  logic m_valid = 1'b0, m_fe = 1'b0, m_ov = 1'b0, m_pe = 1'b0;
  logic [7:0] m_data = 8'h00;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // reference: each frame resolves at its stop-sample cycle k, outputs appear in k+1
  always @(posedge clk) begin : model
    ev_t e;
    logic ld;
    if (!rst_n) begin
      q.delete();
      {m_valid, m_fe, m_ov, m_pe} = 4'b0;
      m_data = 8'h00;
    end else begin
      {ld, m_fe, m_ov, m_pe} = 4'b0;
      if (q.size() > 0 && q[0].s == cyc) begin
        e = q.pop_front();
        if (!e.stop) m_fe = 1'b1;
        else if (!e.par) m_pe = 1'b1;
        else if (!m_valid || rx_ready) ld = 1'b1;
        else m_ov = 1'b1;
      end
      if (ld) begin
        m_valid = 1'b1;
        m_data = e.d;
      end else if (m_valid && rx_ready) m_valid = 1'b0;
    end
    cyc = cyc + 1;
  end
  always @(negedge clk) begin
    chk("rx_valid", 8'(rx_valid), 8'(rst_n ? m_valid : 1'b0));
    chk("rx_data", rx_data, rst_n ? m_data : 8'h00);
    chk("frame_err", 8'(frame_err), 8'(rst_n ? m_fe : 1'b0));
    chk("overrun", 8'(overrun), 8'(rst_n ? m_ov : 1'b0));
    chk("parity_err", 8'(parity_err), 8'(rst_n ? m_pe : 1'b0));
  end
  task automatic tick();
    @(posedge clk);
    #2;
    if (rnd) rx_ready = ($urandom_range(0, 3) == 0);
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask
  task automatic ack();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask
  // rst_at >= 0: pull reset at that cycle offset into the frame, release mid stop bit
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_ok, input int rst_at);
    logic bits [0:10];
    ev_t e;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9] = (^d) ^ PODD ^ !par_ok;
    bits[NB] = stop;
    e.s = cyc + 2 + HALF + NB * CPB;
    e.d = d;
    e.stop = stop;
    e.par = par_ok;
    q.push_back(e);
    for (int i = 0; i <= NB; i++)
      for (int j = 0; j < CPB; j++) begin
        if (i * CPB + j == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk("reset rx_valid", 8'(rx_valid), 8'd0);
          chk("reset rx_data", rx_data, 8'h00);
          chk("reset busy", 8'(busy), 8'd0);
        end
        if (rst_at >= 0 && i == NB && j == HALF) rst_n = 1'b1;
        rx = bits[i];
        tick();
      end
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: no finish after %0d cycles", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    int c, c2, kind;
    ticks(2);
    chk("por rx_valid", 8'(rx_valid), 8'd0);
    chk("por rx_data", rx_data, 8'h00);
    chk("por busy", 8'(busy), 8'd0);
    chk("por frame_err", 8'(frame_err), 8'd0);
    rst_n = 1'b1;
    ticks(3);
    c = cyc;
    fork
      send_frame(8'hA5, 1'b1, 1'b1, -1);
      begin
        wait_cyc(c + 1 + DLY);
        chk("t1 early valid", 8'(rx_valid), 8'd0);
        wait_cyc(c + 2 + DLY);
        chk("t1 valid", 8'(rx_valid), 8'd1);
        chk("t1 data", rx_data, 8'hA5);
      end
    join
    ticks(5);
    chk("t1 held", 8'(rx_valid), 8'd1);
    ack();
    chk("t1 ack", 8'(rx_valid), 8'd0);
    ticks(5);
    c = cyc;
    rx = 1'b0;
    tick();
    chk("t2 busy pre", 8'(busy), 8'd0);
    tick();
    rx = 1'b1;
    wait_cyc(c + 2);
    chk("t2 busy T0", 8'(busy), 8'd1);
    wait_cyc(c + 6);
    chk("t2 busy T0+4", 8'(busy), 8'd1);
    wait_cyc(c + 7);
    chk("t2 busy T0+5", 8'(busy), 8'd0);
    wait_cyc(c + 2 + DLY + 4);
    tick();
    c = cyc;
    fork
      begin
        send_frame(8'h00, 1'b0, 1'b1, -1);
        ticks(40);
        chk("t3 busy low", 8'(busy), 8'd1);
        rx = 1'b1;
      end
      begin
        wait_cyc(c + 1 + DLY);
        chk("t3 fe early", 8'(frame_err), 8'd0);
        wait_cyc(c + 2 + DLY);
        chk("t3 fe", 8'(frame_err), 8'd1);
        chk("t3 no valid", 8'(rx_valid), 8'd0);
        wait_cyc(c + 3 + DLY);
        chk("t3 fe late", 8'(frame_err), 8'd0);
      end
    join
    ticks(4);
    c = cyc;
    fork
      send_frame(8'h3C, 1'b1, 1'b1, -1);
      begin
        wait_cyc(c + 2 + DLY);
        chk("t3 valid", 8'(rx_valid), 8'd1);
        chk("t3 data", rx_data, 8'h3C);
      end
    join
    ack();
    ticks(3);
    send_frame(8'h11, 1'b1, 1'b1, -1);
    c2 = cyc;
    fork
      send_frame(8'h22, 1'b1, 1'b1, -1);
      begin
        wait_cyc(c2 + 2 + DLY);
        chk("t4 overrun", 8'(overrun), 8'd1);
        chk("t4 data kept", rx_data, 8'h11);
        chk("t4 valid kept", 8'(rx_valid), 8'd1);
        wait_cyc(c2 + 3 + DLY);
        chk("t4 overrun late", 8'(overrun), 8'd0);
      end
    join
    ack();
    chk("t4 ack", 8'(rx_valid), 8'd0);
    ticks(3);
    send_frame(8'h77, 1'b1, 1'b1, -1);
    ticks(2);
    send_frame(8'h5A, 1'b1, 1'b1, 4 * CPB + 3);
    ticks(4);
    c = cyc;
    fork
      send_frame(8'hC3, 1'b1, 1'b1, -1);
      begin
        wait_cyc(c + 2 + DLY);
        chk("t5 valid", 8'(rx_valid), 8'd1);
        chk("t5 data", rx_data, 8'hC3);
      end
    join
    ack();
    ticks(3);
    c = cyc;
    fork
      send_frame(8'h03, 1'b1, 1'b1, -1);
      begin
        wait_cyc(c + 2 + DLY);
        chk("t6 valid", 8'(rx_valid), 8'd1);
        chk("t6 data", rx_data, 8'h03);
        chk("t6 parity_err", 8'(parity_err), 8'd0);
      end
    join
    ack();
`ifdef UART_RX_PARITY_EN
    ticks(3);
    c = cyc;
    fork
      send_frame(8'h03, 1'b1, 1'b0, -1);
      begin
        wait_cyc(c + 1 + DLY);
        chk("t6 pe early", 8'(parity_err), 8'd0);
        wait_cyc(c + 2 + DLY);
        chk("t6 pe", 8'(parity_err), 8'd1);
        chk("t6 pe no valid", 8'(rx_valid), 8'd0);
      end
    join
`endif
    ticks(3);
    rnd = 1'b1;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        rx = 1'b0;
        ticks($urandom_range(1, HALF - 1));
        rx = 1'b1;
        ticks(HALF + 3);
      end else if (kind == 1) begin
        send_frame(8'($urandom), 1'b0, 1'b1, -1);
        rx = 1'b1;
        ticks(3);
      end else send_frame(8'($urandom), 1'b1, !(kind == 2 && PEN), -1);
      ticks($urandom_range(0, 12));
    end
    rnd = 1'b0;
    rx_ready = 1'b1;
    ticks(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
